// File: rtl/ram_sp_arbiter_pkg.sv
// Shared types for the single-port RAM arbiter: controller states and requester IDs.
package ram_sp_arbiter_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_e;

endpackage

// File: rtl/ram_sp_arbiter_bram.sv
// Single-port write-first BRAM with 1-cycle read latency and a synchronous output reset.
// Contents have no power-on value; the arbiter's reset sweep zero-fills them.
module ram_sp_arbiter_bram #(
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [Depth];
  logic [DATA_WIDTH-1:0] dout_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q <= '0;
    end else if (we) begin
      dout_q <= din;
    end else begin
      dout_q <= mem_q[addr];
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/ram_sp_arbiter_top.sv
// Arbiter plus its single-port BRAM, presenting only the two client interfaces.
module ram_sp_arbiter_top #(
  parameter int unsigned DATA_WIDTH     = 128,
  parameter int unsigned ADDR_WIDTH     = 12,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_din,
  output logic                  a_gnt,
  output logic                  a_rvalid,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_din,
  output logic                  b_gnt,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  init_done
);

  logic                  ram_rst;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_din;
  logic [DATA_WIDTH-1:0] ram_dout;

  ram_sp_arbiter #(
    .DATA_WIDTH    (DATA_WIDTH),
    .ADDR_WIDTH    (ADDR_WIDTH),
    .CLEAR_ON_RESET(CLEAR_ON_RESET)
  ) u_arb (
    .clk      (clk),
    .rst      (rst),
    .a_req    (a_req),
    .a_we     (a_we),
    .a_addr   (a_addr),
    .a_din    (a_din),
    .a_gnt    (a_gnt),
    .a_rvalid (a_rvalid),
    .b_req    (b_req),
    .b_we     (b_we),
    .b_addr   (b_addr),
    .b_din    (b_din),
    .b_gnt    (b_gnt),
    .b_rvalid (b_rvalid),
    .rdata    (rdata),
    .init_done(init_done),
    .ram_rst  (ram_rst),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_dout (ram_dout)
  );

  ram_sp_arbiter_bram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_bram (
    .clk (clk),
    .rst (ram_rst),
    .we  (ram_we),
    .addr(ram_addr),
    .din (ram_din),
    .dout(ram_dout)
  );

endmodule

// File: rtl/ram_sp_arbiter.sv
// Shares one single-port BRAM between requesters A and B with round-robin grants,
// after zero-filling the whole memory following reset.
module ram_sp_arbiter
  import ram_sp_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 128,
  parameter int unsigned ADDR_WIDTH     = 12,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_din,
  output logic                  a_gnt,
  output logic                  a_rvalid,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_din,
  output logic                  b_gnt,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  init_done,
  output logic                  ram_rst,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  localparam logic [ADDR_WIDTH-1:0] LastAddr   = '1;
  localparam state_e                ResetState = CLEAR_ON_RESET ? ST_INIT : ST_RUN;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic [ADDR_WIDTH-1:0] addr_hold_q;
  req_id_e               last_gnt_q, last_gnt_d;
  logic                  a_rvalid_q, b_rvalid_q;
  logic                  init_done_q;

  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    last_gnt_d = last_gnt_q;
    a_gnt      = 1'b0;
    b_gnt      = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = addr_hold_q;
    ram_din    = '0;

    // Everything stays quiet while reset is asserted.
    if (rst) begin
      case (state_q)
        ST_INIT: begin
          ram_we   = 1'b1;
          ram_addr = clr_cnt_q;
          // Terminal-count compare: the counter parks on the last address, never wraps.
          if (clr_cnt_q == LastAddr) begin
            state_d = ST_RUN;
          end else begin
            clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
          end
        end
        ST_RUN: begin
          if (a_req && (!b_req || last_gnt_q == REQ_B)) begin
            a_gnt = 1'b1;
          end else if (b_req) begin
            b_gnt = 1'b1;
          end

          if (a_gnt) begin
            ram_we     = a_we;
            ram_addr   = a_addr;
            ram_din    = a_din;
            last_gnt_d = REQ_A;
          end else if (b_gnt) begin
            ram_we     = b_we;
            ram_addr   = b_addr;
            ram_din    = b_din;
            last_gnt_d = REQ_B;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ResetState;
      clr_cnt_q   <= '0;
      last_gnt_q  <= REQ_B;
      a_rvalid_q  <= 1'b0;
      b_rvalid_q  <= 1'b0;
      init_done_q <= !CLEAR_ON_RESET;
      addr_hold_q <= '0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      last_gnt_q  <= last_gnt_d;
      a_rvalid_q  <= a_gnt;
      b_rvalid_q  <= b_gnt;
      init_done_q <= (state_d == ST_RUN);
      addr_hold_q <= ram_addr;
    end
  end

  assign a_rvalid  = a_rvalid_q;
  assign b_rvalid  = b_rvalid_q;
  assign init_done = init_done_q;
  assign rdata     = ram_dout;
  assign ram_rst   = !rst;

endmodule

// File: tb/tb_ram_sp_arbiter.sv
// Bench for ram_sp_arbiter: directed scenarios plus random traffic against a
// cycle-level reference model of memory contents, grant order and read results.
module tb_ram_sp_arbiter;

  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 4;
  localparam int unsigned Depth = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b0;
  logic          a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_din = '0, b_din = '0;
  logic          a_gnt, a_rvalid, b_gnt, b_rvalid, init_done, ram_rst, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din, rdata;
  logic [DW-1:0] ram_dout = '0;

  ram_sp_arbiter #(
    .DATA_WIDTH    (DW),
    .ADDR_WIDTH    (AW),
    .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .a_req    (a_req),
    .a_we     (a_we),
    .a_addr   (a_addr),
    .a_din    (a_din),
    .a_gnt    (a_gnt),
    .a_rvalid (a_rvalid),
    .b_req    (b_req),
    .b_we     (b_we),
    .b_addr   (b_addr),
    .b_din    (b_din),
    .b_gnt    (b_gnt),
    .b_rvalid (b_rvalid),
    .rdata    (rdata),
    .init_done(init_done),
    .ram_rst  (ram_rst),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_dout (ram_dout)
  );

  // Behavioural single-port write-first RAM
  logic [DW-1:0] ram_mem [Depth];
  always @(posedge clk) begin
    if (ram_rst) begin
      ram_dout <= '0;
    end else if (ram_we) begin
      ram_mem[ram_addr] <= ram_din;
      ram_dout          <= ram_din;
    end else begin
      ram_dout <= ram_mem[ram_addr];
    end
  end

  // Second instance without the sweep, wrapped with the real BRAM
  logic          z_rst = 1'b0, z_a_req = 1'b0, z_a_we = 1'b0;
  logic [AW-1:0] z_a_addr = '0;
  logic [DW-1:0] z_a_din = '0;
  logic          z_a_gnt, z_a_rvalid, z_b_gnt, z_b_rvalid, z_init_done;
  logic [DW-1:0] z_rdata;

  ram_sp_arbiter_top #(
    .DATA_WIDTH    (DW),
    .ADDR_WIDTH    (AW),
    .CLEAR_ON_RESET(1'b0)
  ) dut0 (
    .clk      (clk),
    .rst      (z_rst),
    .a_req    (z_a_req),
    .a_we     (z_a_we),
    .a_addr   (z_a_addr),
    .a_din    (z_a_din),
    .a_gnt    (z_a_gnt),
    .a_rvalid (z_a_rvalid),
    .b_req    (1'b0),
    .b_we     (1'b0),
    .b_addr   ('0),
    .b_din    ('0),
    .b_gnt    (z_b_gnt),
    .b_rvalid (z_b_rvalid),
    .rdata    (z_rdata),
    .init_done(z_init_done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  bit            m_init   = 1'b1;
  int            m_cnt    = 0;
  bit            m_last_b = 1'b1;
  bit            m_done   = 1'b0;
  bit            m_pa     = 1'b0;
  bit            m_pb     = 1'b0;
  logic [DW-1:0] m_rd     = '0;
  logic [DW-1:0] m_mem [Depth];
  bit            e_a, e_b;

  // One clock cycle: check outputs at the falling edge, then advance the model.
  task automatic cyc();
    @(negedge clk);
    e_a = 1'b0;
    e_b = 1'b0;
    if (rst && !m_init) begin
      if (a_req && b_req) begin
        e_a = m_last_b;
        e_b = !m_last_b;
      end else begin
        e_a = a_req;
        e_b = b_req;
      end
    end
    check_eq("a_gnt", a_gnt, e_a);
    check_eq("b_gnt", b_gnt, e_b);
    check_eq("a_rvalid", a_rvalid, m_pa);
    check_eq("b_rvalid", b_rvalid, m_pb);
    check_eq("init_done", init_done, m_done);
    if (m_pa || m_pb) check_eq("rdata", rdata, m_rd);
    if (!rst) begin
      check_eq("ram_we_rst", ram_we, 0);
    end else if (m_init) begin
      check_eq("sweep_we", ram_we, 1);
      check_eq("sweep_addr", ram_addr, m_cnt);
      check_eq("sweep_din", ram_din, 0);
    end else if (e_a || e_b) begin
      check_eq("ram_we", ram_we, e_a ? a_we : b_we);
      check_eq("ram_addr", ram_addr, e_a ? a_addr : b_addr);
      if (ram_we) check_eq("ram_din", ram_din, e_a ? a_din : b_din);
    end else begin
      check_eq("ram_we_idle", ram_we, 0);
    end

    @(posedge clk);
    if (!rst) begin
      m_init   = 1'b1;
      m_cnt    = 0;
      m_last_b = 1'b1;
      m_pa     = 1'b0;
      m_pb     = 1'b0;
      m_done   = 1'b0;
    end else begin
      m_pa = e_a;
      m_pb = e_b;
      if (m_init) begin
        m_mem[m_cnt] = '0;
        if (m_cnt == Depth - 1) begin
          m_init = 1'b0;
          m_done = 1'b1;
        end else begin
          m_cnt++;
        end
      end else if (e_a) begin
        if (a_we) m_mem[a_addr] = a_din;
        m_rd     = m_mem[a_addr];
        m_last_b = 1'b0;
      end else if (e_b) begin
        if (b_we) m_mem[b_addr] = b_din;
        m_rd     = m_mem[b_addr];
        m_last_b = 1'b1;
      end
    end
    #1;
  endtask

  // Runs until init_done, bounded; returns the number of cycles taken.
  task automatic run_sweep(output int n);
    n = 0;
    while (!init_done && n < 40) begin
      cyc();
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    repeat (2) @(posedge clk);
    #1;
    // Reset state, with a request held that must be ignored
    a_req = 1'b1;
    cyc();

    // Sweep after release: 16 writes, then A wins the first RUN cycle
    rst = 1'b1;
    run_sweep(n);
    check_eq("sweep_len", n, 16);
    check_eq("first_run_gnt", a_gnt, 1);
    cyc();

    // A writes 0xA5 @3, reads it back
    a_we = 1'b1; a_addr = 4'd3; a_din = 8'hA5;
    cyc();
    a_we = 1'b0;
    cyc();
    a_req = 1'b0;
    cyc();
    check_eq("t2_rdata", rdata, 8'hA5);

    // Both requesting continuously
    a_req = 1'b1; a_we = 1'b1; a_addr = 4'd1; a_din = 8'h5A;
    b_req = 1'b1; b_we = 1'b0; b_addr = 4'd2;
    repeat (6) cyc();
    a_req = 1'b0; b_req = 1'b0;
    cyc();

    // B alone: back-to-back writes then reads
    for (int i = 0; i < 4; i++) begin
      b_req = 1'b1; b_we = 1'b1; b_addr = AW'(i); b_din = DW'(8'h10 + i);
      cyc();
    end
    for (int i = 0; i < 4; i++) begin
      b_we = 1'b0; b_addr = AW'(i);
      cyc();
    end
    b_req = 1'b0;
    cyc();
    check_eq("t7_last_rdata", rdata, 8'h13);

    // Reset while a read result is pending
    a_req = 1'b1; a_we = 1'b0; a_addr = 4'd3;
    cyc();
    a_req = 1'b0; rst = 1'b0;
    cyc();
    check_eq("t6_rvalid_cleared", a_rvalid, 0);
    rst = 1'b1;

    // Abort the sweep at address 7, then a full restart
    repeat (7) cyc();
    check_eq("t5_abort_addr", ram_addr, 7);
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    run_sweep(n);
    check_eq("sweep_len_restart", n, 16);

    // Random traffic, occasional resets
    for (int i = 0; i < 500; i++) begin
      rst = ($urandom_range(0, 149) != 0);
      if (!a_req && $urandom_range(0, 1) == 1) begin
        a_req = 1'b1; a_we = 1'($urandom_range(0, 1));
        a_addr = AW'($urandom); a_din = DW'($urandom);
      end
      if (!b_req && $urandom_range(0, 1) == 1) begin
        b_req = 1'b1; b_we = 1'($urandom_range(0, 1));
        b_addr = AW'($urandom); b_din = DW'($urandom);
      end
      cyc();
      if (e_a) begin
        a_req = ($urandom_range(0, 3) != 0); a_we = 1'($urandom_range(0, 1));
        a_addr = AW'($urandom); a_din = DW'($urandom);
      end
      if (e_b) begin
        b_req = ($urandom_range(0, 3) != 0); b_we = 1'($urandom_range(0, 1));
        b_addr = AW'($urandom); b_din = DW'($urandom);
      end
    end
    rst = 1'b1; a_req = 1'b0; b_req = 1'b0;
    repeat (20) cyc();

    // No-sweep instance: usable in the first cycle after release
    z_a_req = 1'b1; z_a_we = 1'b1; z_a_addr = 4'd5; z_a_din = 8'h3C;
    z_rst = 1'b1;
    @(negedge clk);
    check_eq("z_init_done", z_init_done, 1);
    check_eq("z_first_gnt", z_a_gnt, 1);
    check_eq("z_first_rvalid", z_a_rvalid, 0);
    @(posedge clk);
    #1;
    z_a_we = 1'b0;
    @(negedge clk);
    check_eq("z_wr_rvalid", z_a_rvalid, 1);
    check_eq("z_wr_rdata", z_rdata, 8'h3C);
    check_eq("z_rd_gnt", z_a_gnt, 1);
    @(posedge clk);
    #1;
    z_a_req = 1'b0;
    @(negedge clk);
    check_eq("z_rd_rvalid", z_a_rvalid, 1);
    check_eq("z_rd_rdata", z_rdata, 8'h3C);
    check_eq("z_idle_gnt", z_a_gnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
